// File: rtl/hc138_scan_pkg.sv
// Shared types and constants for the hc138 scan sequencer.
// Also provides a helper that returns the lowest set bit of a channel mask.
package hc138_scan_pkg;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

   localparam int NUM_CH = 8;
   localparam int ADDR_W = 3;
   localparam logic [2:0] EN_ON  = 3'b111;
   localparam logic [2:0] EN_OFF = 3'b000;

   function automatic logic [ADDR_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
      lowest_bit = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_bit = ADDR_W'(i);
   endfunction

endpackage

// File: rtl/hc138_scan_next_ch.sv
// Combinational channel picker: next set bit above cur (wrapping), wrap flag, lowest set bit.
// A mask with only cur set yields next == cur and wrap == 1.
module hc138_scan_next_ch
   import hc138_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [ADDR_W-1:0] cur_i,
   output logic [ADDR_W-1:0] next_o,
   output logic              wrap_o,
   output logic [ADDR_W-1:0] first_o
);

   logic              found;
   logic [ADDR_W-1:0] idx;

   always_comb begin
      next_o = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = cur_i + ADDR_W'(i);
         if (!found && mask_i[idx]) begin
            next_o = idx;
            found  = 1'b1;
         end
      end
   end

   assign wrap_o  = (next_o <= cur_i);
   assign first_o = lowest_bit(mask_i);

endmodule

// File: rtl/hc138_scan_seq.sv
// Scan sequencer driving an hc138 decoder: blank gap, then dwell per enabled channel.
// Optional frame counter output when HC138_SCAN_STATS_EN is defined.
module hc138_scan_seq
   import hc138_scan_pkg::*;
#(
   parameter int DWELL_W      = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               continuous_i,
   input  logic [NUM_CH-1:0]  chan_mask_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [2:0]         en_o,
   output logic               busy_o,
   output logic               frame_done_o
`ifdef HC138_SCAN_STATS_EN
   ,output logic [15:0]       frame_cnt_o
`endif
);

   localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYCLES - 1);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [2:0]         en_q, en_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;

   logic [ADDR_W-1:0]  nxt_ch, first_ch;
   logic               wrap;
   logic               go, blank_end, dwell_end, new_mask_nz;

   hc138_scan_next_ch u_next_ch (
      .mask_i  (mask_q),
      .cur_i   (addr_q),
      .next_o  (nxt_ch),
      .wrap_o  (wrap),
      .first_o (first_ch)
   );

   assign new_mask_nz = (chan_mask_i != '0);
   assign go          = start_i && !stop_i && new_mask_nz;
   assign blank_end   = (cnt_q == BLANK_LAST);
   assign dwell_end   = (cnt_q == dwell_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (go) state_d = BLANK;
         BLANK: begin
            if (stop_i)         state_d = IDLE;
            else if (blank_end) state_d = DRIVE;
         end
         DRIVE: begin
            if (stop_i) state_d = IDLE;
            else if (dwell_end) begin
               if (!wrap)                      state_d = BLANK;
               else if (cont_q && new_mask_nz) state_d = BLANK;
               else                            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One shared counter times both the blank gap and the dwell.
   always_comb begin
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      mask_d       = mask_q;
      dwell_d      = dwell_q;
      cont_d       = cont_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (go) begin
               mask_d  = chan_mask_i;
               dwell_d = dwell_i;
               cont_d  = continuous_i;
               addr_d  = lowest_bit(chan_mask_i);
            end
         end
         BLANK: begin
            if (stop_i || blank_end) cnt_d = '0;
            else                     cnt_d = cnt_q + DWELL_W'(1);
         end
         DRIVE: begin
            if (stop_i) cnt_d = '0;
            else if (dwell_end) begin
               cnt_d = '0;
               if (!wrap) addr_d = nxt_ch;
               else begin
                  frame_done_d = 1'b1;
                  if (cont_q) begin
                     mask_d  = chan_mask_i;
                     dwell_d = dwell_i;
                     cont_d  = continuous_i;
                     if (new_mask_nz) addr_d = lowest_bit(chan_mask_i);
                  end
               end
            end else cnt_d = cnt_q + DWELL_W'(1);
         end
         default: cnt_d = '0;
      endcase
      en_d   = (state_d == DRIVE) ? EN_ON : EN_OFF;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q       <= '0;
         en_q         <= EN_OFF;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cnt_q        <= '0;
         mask_q       <= '0;
         dwell_q      <= '0;
         cont_q       <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         en_q         <= en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         dwell_q      <= dwell_d;
         cont_q       <= cont_d;
      end
   end

   assign addr_o       = addr_q;
   assign en_o         = en_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;

   // first_ch mirrors lowest_bit(mask_q); only the IDLE/relatch paths need the live mask.
   logic first_unused;
   assign first_unused = ^first_ch;

`ifdef HC138_SCAN_STATS_EN
   logic [15:0] frame_cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i)             frame_cnt_q <= '0;
      else if (frame_done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
   end
   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_hc138_scan_seq.sv
// Scoreboard bench for hc138_scan_seq: expected drive/frame_done events queued with their cycle.
// A monitor pops and compares whenever en=111 or frame_done is seen.
module tb_hc138_scan_seq;

   localparam int DWELL_W = 16;
   localparam int BLANK   = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               start_i, stop_i, continuous_i;
   logic [7:0]         chan_mask_i;
   logic [DWELL_W-1:0] dwell_i;
   logic [2:0]         addr_o;
   logic [2:0]         en_o;
   logic               busy_o, frame_done_o;
`ifdef HC138_SCAN_STATS_EN
   logic [15:0]        frame_cnt_o;
`endif

   hc138_scan_seq #(.DWELL_W(DWELL_W), .BLANK_CYCLES(BLANK)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .continuous_i (continuous_i),
      .chan_mask_i  (chan_mask_i),
      .dwell_i      (dwell_i),
      .addr_o       (addr_o),
      .en_o         (en_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o)
`ifdef HC138_SCAN_STATS_EN
      ,.frame_cnt_o (frame_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       done;
      logic [2:0] addr;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // s0 = cycle in which start (or the previous frame's last drive) is seen.
   task automatic push_frame(input int s0, input logic [7:0] m, input int dw, output int t);
      ev_t e;
      t = s0;
      for (int ch = 0; ch < 8; ch++) begin
         if (m[ch]) begin
            t += BLANK;
            for (int d = 0; d <= dw; d++) begin
               t++;
               e.cyc = t; e.done = 1'b0; e.addr = 3'(ch);
               exp_q.push_back(e);
            end
         end
      end
      e.cyc = t + 1; e.done = 1'b1; e.addr = 3'd0;
      exp_q.push_back(e);
   endtask

   task automatic push_drive(input int c, input logic [2:0] a);
      ev_t e;
      e.cyc = c; e.done = 1'b0; e.addr = a;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk_i);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clk_i);
         k++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic pulse_start(output int s);
      start_i = 1'b1;
      s = cyc;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   // Monitor and protocol checker.
   initial begin
      ev_t        e;
      logic       prev_on;
      logic [2:0] prev_addr;
      prev_on   = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) prev_on = 1'b0;
         else begin
            chk("en_legal", int'(en_o == 3'b000 || en_o == 3'b111), 1);
            if (en_o == 3'b111) begin
               chk("busy_in_drive", int'(busy_o), 1);
               if (prev_on) chk("addr_stable", int'(addr_o), int'(prev_addr));
            end
            if (en_o == 3'b111 || frame_done_o) begin
               if (exp_q.size() == 0) chk("unexpected_event", cyc, -1);
               else begin
                  e = exp_q.pop_front();
                  chk("event_cycle", cyc, e.cyc);
                  chk("event_is_done", int'(frame_done_o), int'(e.done));
                  if (!e.done) chk("drive_addr", int'(addr_o), int'(e.addr));
               end
            end
            prev_on   = (en_o == 3'b111);
            prev_addr = addr_o;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: no finish by cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, t;
      rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; continuous_i = 1'b0;
      chan_mask_i = '0; dwell_i = '0;
      step(3);
      chk("rst_addr", int'(addr_o), 0);
      chk("rst_en", int'(en_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_frame_done", int'(frame_done_o), 0);
`ifdef HC138_SCAN_STATS_EN
      chk("rst_frame_cnt", int'(frame_cnt_o), 0);
`endif
      rst_i = 1'b0;
      step(1);

      // Empty mask: start ignored
      chan_mask_i = 8'h00;
      pulse_start(s);
      step(3);
      chk("mask0_busy", int'(busy_o), 0);
      chk("mask0_en", int'(en_o), 0);

      // All channels, dwell 0, single frame: frame_done at start+25
      chan_mask_i = 8'hFF; dwell_i = 0; continuous_i = 1'b0;
      pulse_start(s);
      push_frame(s, 8'hFF, 0, t);
      chk("ff_done_at_25", t + 1 - s, 25);
      drain("ff_drain");
      step(3);
      chk("ff_idle_busy", int'(busy_o), 0);
      chk("ff_hold_addr", int'(addr_o), 7);
`ifdef HC138_SCAN_STATS_EN
      chk("ff_frame_cnt", int'(frame_cnt_o), 1);
`endif

      // Continuous ch1/ch7 dwell 3; mid-frame change to ch0, dwell 1, single
      chan_mask_i = 8'b1000_0010; dwell_i = 3; continuous_i = 1'b1;
      pulse_start(s);
      push_frame(s, 8'b1000_0010, 3, t);
      chk("cont_frame_len", t - s, 12);
      push_frame(t, 8'b1000_0010, 3, t);
      push_frame(t, 8'h01, 1, t);
      wait_cyc(s + 16);
      chan_mask_i = 8'h01; dwell_i = 1; continuous_i = 1'b0;
      drain("cont_drain");
      step(3);
      chk("cont_idle_busy", int'(busy_o), 0);
`ifdef HC138_SCAN_STATS_EN
      chk("cont_frame_cnt", int'(frame_cnt_o), 4);
`endif

      // Stop during DRIVE of ch5
      chan_mask_i = 8'h20; dwell_i = 5; continuous_i = 1'b0;
      pulse_start(s);
      push_drive(s + 3, 3'd5);
      push_drive(s + 4, 3'd5);
      wait_cyc(s + 4);
      stop_i = 1'b1;
      step(1);
      stop_i = 1'b0;
      chk("stop_en", int'(en_o), 0);
      chk("stop_busy", int'(busy_o), 0);
      drain("stop_drain");

      // Stop in final drive cycle suppresses frame_done
      dwell_i = 0;
      pulse_start(s);
      push_drive(s + 3, 3'd5);
      wait_cyc(s + 3);
      stop_i = 1'b1;
      step(1);
      stop_i = 1'b0;
      chk("stop_last_fd", int'(frame_done_o), 0);
      drain("stop_last_drain");
      step(3);

      // start and stop together in IDLE
      start_i = 1'b1; stop_i = 1'b1;
      step(1);
      start_i = 1'b0; stop_i = 1'b0;
      step(3);
      chk("startstop_busy", int'(busy_o), 0);

      // Reset mid-DRIVE
      chan_mask_i = 8'h08; dwell_i = 2; continuous_i = 1'b1;
      pulse_start(s);
      push_drive(s + 3, 3'd3);
      push_drive(s + 4, 3'd3);
      wait_cyc(s + 4);
      rst_i = 1'b1;
      step(1);
      chk("rst2_addr", int'(addr_o), 0);
      chk("rst2_en", int'(en_o), 0);
      chk("rst2_busy", int'(busy_o), 0);
      chk("rst2_frame_done", int'(frame_done_o), 0);
`ifdef HC138_SCAN_STATS_EN
      chk("rst2_frame_cnt", int'(frame_cnt_o), 0);
`endif
      rst_i = 1'b0; chan_mask_i = 8'h00; continuous_i = 1'b0;
      drain("rst2_drain");
      step(4);
      chk("final_busy", int'(busy_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
